// File: rtl/load_bus_arbiter.sv
// load_bus_arbiter: round-robin sharing of the tagged {data, LOAD} load bus between two requesters.
// Optional macro LOAD_TIMEOUT_EN adds a BUSY timeout that aborts a stalled transfer and pulses ERR.
module load_bus_arbiter #(
    parameter int unsigned DW = 32
`ifdef LOAD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          REQ0,
    input  logic [DW-1:0] DATA0,
    output logic          ACK0,
    input  logic          REQ1,
    input  logic [DW-1:0] DATA1,
    output logic          ACK1,
    input  logic          BUSY,
    output logic [DW:0]   BUS_OUT,
    output logic [1:0]    GNT,
    output logic          ERR
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          load;
    } bus_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 4) ? 4 : CW_RAW;
`endif

    state_t    state_q, state_d;
    bus_word_t bus_q, bus_d;
    logic [1:0] gnt_q, gnt_d;
    logic      last_q, last_d;
    logic      ack0_q, ack0_d;
    logic      ack1_q, ack1_d;
    logic      sel;
    logic      done;
`ifdef LOAD_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // State and output registers; LAST resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            bus_q   <= '0;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
`ifdef LOAD_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the word in XFER until BUSY drops (or timeout).
    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        sel     = 1'b0;
        done    = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // On a tie, the requester that was not served last wins.
                if (REQ0 && REQ1) begin
                    sel = ~last_q;
                end else begin
                    sel = REQ1;
                end
                if (REQ0 || REQ1) begin
                    bus_d.data = sel ? DATA1 : DATA0;
                    bus_d.load = 1'b1;
                    gnt_d      = sel ? 2'b10 : 2'b01;
                    state_d    = XFER;
`ifdef LOAD_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            XFER: begin
                if (!BUSY) begin
                    done = 1'b1;
`ifdef LOAD_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This edge is the TIMEOUT-th consecutive BUSY edge: give up on the word.
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
                if (done) begin
                    ack0_d  = gnt_q[0];
                    ack1_d  = gnt_q[1];
                    bus_d   = '0;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = IDLE;
`ifdef LOAD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BUS_OUT = bus_q;
    assign GNT     = gnt_q;
    assign ACK0    = ack0_q;
    assign ACK1    = ack1_q;
`ifdef LOAD_TIMEOUT_EN
    assign ERR     = err_q;
`else
    assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_load_bus_arbiter.sv
// tb_load_bus_arbiter: directed bench with a word scoreboard for load_bus_arbiter.
// Covers both builds; the timeout scenario branches on LOAD_TIMEOUT_EN.
module tb_load_bus_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        REQ0, REQ1, BUSY;
    logic [31:0] DATA0, DATA1;
    logic        ACK0, ACK1, ERR;
    logic [32:0] BUS_OUT;
    logic [1:0]  GNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [32:0] word;
        logic [1:0]  gnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_load = 1'b0;

    load_bus_arbiter #(.DW(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .REQ0(REQ0), .DATA0(DATA0), .ACK0(ACK0),
        .REQ1(REQ1), .DATA1(DATA1), .ACK1(ACK1),
        .BUSY(BUSY), .BUS_OUT(BUS_OUT), .GNT(GNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_bus"}, BUS_OUT, 33'h0);
        chk({tag, "_gnt"}, 33'(GNT), 33'h0);
        chk({tag, "_ack"}, 33'({ACK1, ACK0}), 33'h0);
        chk({tag, "_err"}, 33'(ERR), 33'h0);
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] g);
        exp_t e;
        e.word = {d, 1'b1};
        e.gnt  = g;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: each new LOAD word and each ACK is matched against the expected queue.
    always @(negedge CLK) begin
        if (BUS_OUT[0] && !prev_load) begin
            if (sb.size() == 0) begin
                chk("sb_word_unexpected", BUS_OUT, 33'h0);
            end else begin
                chk("sb_word", BUS_OUT, sb[0].word);
                chk("sb_gnt", 33'(GNT), 33'(sb[0].gnt));
            end
        end
        if (ACK0 || ACK1) begin
            if (sb.size() == 0) begin
                chk("sb_ack_unexpected", 33'({ACK1, ACK0}), 33'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_ack", 33'({ACK1, ACK0}), 33'(mon_e.gnt));
            end
        end
        prev_load = BUS_OUT[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; BUSY = 1'b0;
        DATA0 = 32'h0; DATA1 = 32'h0;

        // Reset state and idle bus
        @(negedge CLK);
        chk_idle("reset");
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_idle("idle");
        end

        // Single word from requester 0, minimum latency
        DATA0 = 32'd255; REQ0 = 1'b1; push(32'd255, 2'b01);
        @(negedge CLK);
        chk("single_bus", BUS_OUT, 33'h1FF);
        chk("single_gnt", 33'(GNT), 33'h1);
        chk("single_noack", 33'({ACK1, ACK0}), 33'h0);
        @(negedge CLK);
        chk("single_ack0", 33'(ACK0), 33'h1);
        chk("single_ack_bus", BUS_OUT, 33'h0);
        chk("single_ack_gnt", 33'(GNT), 33'h0);
        REQ0 = 1'b0;
        @(negedge CLK);
        chk_idle("single_after");

        // Fresh reset so requester 0 wins the first tie again
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        // Both requesters saturating: alternate, one word every two cycles
        DATA0 = 32'hAAAA0000; DATA1 = 32'h5555FFFF; REQ0 = 1'b1; REQ1 = 1'b1;
        for (int k = 0; k < 4; k++) push((k % 2 == 0) ? DATA0 : DATA1, (k % 2 == 0) ? 2'b01 : 2'b10);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("rr_bus", BUS_OUT, (k % 2 == 0) ? 33'h155540001 : 33'h0AAABFFFF);
            chk("rr_gnt", 33'(GNT), (k % 2 == 0) ? 33'h1 : 33'h2);
            @(negedge CLK);
            chk("rr_ack", 33'({ACK1, ACK0}), (k % 2 == 0) ? 33'h1 : 33'h2);
            chk("rr_ack_bus", BUS_OUT, 33'h0);
            if (k == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
        @(negedge CLK);
        chk_idle("rr_after");

        // Requester 1 stalled by three BUSY cycles
        DATA1 = 32'h12345678; REQ1 = 1'b1; BUSY = 1'b1; push(DATA1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("busy_bus", BUS_OUT, 33'h02468ACF1);
            chk("busy_gnt", 33'(GNT), 33'h2);
            chk("busy_noack", 33'({ACK1, ACK0}), 33'h0);
            chk("busy_err", 33'(ERR), 33'h0);
            if (i == 3) BUSY = 1'b0;
        end
        @(negedge CLK);
        chk("busy_ack1", 33'({ACK1, ACK0}), 33'h2);
        chk("busy_ack_bus", BUS_OUT, 33'h0);
        REQ1 = 1'b0;
        @(negedge CLK);
        chk_idle("busy_after");

        // Requester 0 with BUSY stuck high
        DATA0 = 32'd255; REQ0 = 1'b1; BUSY = 1'b1; push(DATA0, 2'b01);
`ifdef LOAD_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            chk("to_hold_bus", BUS_OUT, 33'h1FF);
            chk("to_hold_err", 33'(ERR), 33'h0);
            chk("to_hold_noack", 33'({ACK1, ACK0}), 33'h0);
        end
        @(negedge CLK);
        chk("to_err", 33'(ERR), 33'h1);
        chk("to_ack0", 33'({ACK1, ACK0}), 33'h1);
        chk("to_bus", BUS_OUT, 33'h0);
        chk("to_gnt", 33'(GNT), 33'h0);
        REQ0 = 1'b0; BUSY = 1'b0;
        @(negedge CLK);
        chk_idle("to_after");
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("stuck_bus", BUS_OUT, 33'h1FF);
            chk("stuck_err", 33'(ERR), 33'h0);
            chk("stuck_noack", 33'({ACK1, ACK0}), 33'h0);
        end
        BUSY = 1'b0;
        @(negedge CLK);
        chk("stuck_ack0", 33'({ACK1, ACK0}), 33'h1);
        chk("stuck_err_end", 33'(ERR), 33'h0);
        REQ0 = 1'b0;
        @(negedge CLK);
        chk_idle("stuck_after");
`endif

        // Asynchronous reset in the middle of a transfer
        DATA0 = 32'd255; REQ0 = 1'b1; BUSY = 1'b1; push(DATA0, 2'b01);
        @(negedge CLK);
        chk("rst_mid_bus", BUS_OUT, 33'h1FF);
        @(negedge CLK);
        chk("rst_mid_hold", BUS_OUT, 33'h1FF);
        #2 nRST = 1'b0;
        sb.delete();
        #1;
        chk("rst_async_bus", BUS_OUT, 33'h0);
        chk("rst_async_gnt", 33'(GNT), 33'h0);
        chk("rst_async_ack", 33'({ACK1, ACK0}), 33'h0);
        DATA1 = 32'hCAFE0001; REQ1 = 1'b1; BUSY = 1'b0;
        @(negedge CLK);
        chk("rst_no_ack", 33'({ACK1, ACK0}), 33'h0);
        nRST = 1'b1;
        push(DATA0, 2'b01);
        push(DATA1, 2'b10);
        @(negedge CLK);
        chk("rst_first_gnt", 33'(GNT), 33'h1);
        chk("rst_first_bus", BUS_OUT, 33'h1FF);
        @(negedge CLK);
        chk("rst_first_ack", 33'({ACK1, ACK0}), 33'h1);
        REQ0 = 1'b0;
        @(negedge CLK);
        chk("rst_second_gnt", 33'(GNT), 33'h2);
        chk("rst_second_bus", BUS_OUT, 33'h195FC0003);
        @(negedge CLK);
        chk("rst_second_ack", 33'({ACK1, ACK0}), 33'h2);
        REQ1 = 1'b0;
        @(negedge CLK);
        chk_idle("final");
        chk("sb_drained", 33'(sb.size()), 33'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
